pattern_resp_misr: RTL and testbench



---
 rtl/pattern_harness_pkg.sv | 30 +++
 rtl/pattern_resp_misr_misr_core.sv | 41 ++++
 rtl/pattern_resp_misr.sv | 137 +++++++++++++
 tb/tb_pattern_resp_misr.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_harness_pkg.sv
// Shared definitions for the pattern_11_15 response-capture harness.
//   - misr_state_e : 2-bit run-control FSM state
//   - RESP_W_DEF   : width of the packed pattern-block response word
//   - IDX_*        : bit positions of the 9 pattern outputs inside resp_in
//   - POLY_DEF / SEED_DEF : default MISR feedback polynomial and seed
package pattern_harness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_DONE   = 2'd3
  } misr_state_e;

  localparam int unsigned RESP_W_DEF = 9;

  localparam int unsigned IDX_G42         = 0;
  localparam int unsigned IDX_N_572       = 1;
  localparam int unsigned IDX_N_573       = 2;
  localparam int unsigned IDX_N_549       = 3;
  localparam int unsigned IDX_N_569       = 4;
  localparam int unsigned IDX_ACVQN2      = 5;
  localparam int unsigned IDX_N_266_AND_0 = 6;
  localparam int unsigned IDX_G199        = 7;
  localparam int unsigned IDX_G214        = 8;

  localparam logic [15:0] POLY_DEF = 16'h1021;
  localparam logic [15:0] SEED_DEF = 16'h0000;

endpackage

// File: rtl/pattern_resp_misr_misr_core.sv
// Signature register of the response compactor.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (register -> seed)
//   load            : load seed (highest priority after reset)
//   en              : fold resp_in into the signature this edge
//   seed, poly      : seed value and feedback polynomial
//   resp_in         : response word, zero-extended to SIG_W
//   sig_o           : current signature
//   sig_next_o      : value the signature takes if en is asserted
module misr_core #(
  parameter int unsigned SIG_W  = 16,
  parameter int unsigned RESP_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [SIG_W-1:0]  seed,
  input  logic [SIG_W-1:0]  poly,
  input  logic [RESP_W-1:0] resp_in,
  output logic [SIG_W-1:0]  sig_o,
  output logic [SIG_W-1:0]  sig_next_o
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_next_o = (sig_q << 1) ^ (sig_q[SIG_W-1] ? poly : '0) ^ SIG_W'(resp_in);
    sig_d      = sig_q;
    if (load)    sig_d = seed;
    else if (en) sig_d = sig_next_o;
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= seed;
    else     sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/pattern_resp_misr.sv
// Response-capture stage: compacts the pattern block's 9 registered outputs
// into a MISR under a start/done handshake and compares against a golden value.
// Ports:
//   blif_clk_net_1_r_15   : clock (shared with the pattern block)
//   blif_reset_net_1_r_15 : synchronous active-high reset
//   start / clear         : begin a run / abort to IDLE (clear wins)
//   num_vec, golden       : run length and expected signature, sampled on start
//   resp_in, resp_valid   : upstream response word and its qualifier
//   busy, done, pass      : run status; pass is valid while done
//   signature, vec_cnt    : current MISR contents and accepted-response count
module pattern_resp_misr
  import pattern_harness_pkg::*;
#(
  parameter int unsigned      SIG_W      = 16,
  parameter int unsigned      RESP_W     = RESP_W_DEF,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED       = SIG_W'(SEED_DEF),
  parameter int unsigned      CNT_W      = 12,
  parameter int unsigned      SETTLE_CYC = 2
) (
  input  logic              blif_clk_net_1_r_15,
  input  logic              blif_reset_net_1_r_15,
  input  logic              start,
  input  logic              clear,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [SIG_W-1:0]  golden,
  input  logic [RESP_W-1:0] resp_in,
  input  logic              resp_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  vec_cnt
);

  misr_state_e      state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [SIG_W-1:0] golden_q, golden_d;
  logic             pass_q, pass_d;
  logic             misr_load, misr_en;
  logic [SIG_W-1:0] sig_next;

  misr_core #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W)
  ) u_misr_core (
    .clk        (blif_clk_net_1_r_15),
    .rst        (blif_reset_net_1_r_15),
    .load       (misr_load),
    .en         (misr_en),
    .seed       (SEED),
    .poly       (POLY),
    .resp_in    (resp_in),
    .sig_o      (signature),
    .sig_next_o (sig_next)
  );

  always_comb begin
    state_d   = state_q;
    vec_cnt_d = vec_cnt_q;
    num_d     = num_q;
    settle_d  = settle_q;
    golden_d  = golden_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;

    if (clear) begin
      state_d   = ST_IDLE;
      vec_cnt_d = '0;
      settle_d  = '0;
      pass_d    = 1'b0;
      misr_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_d     = num_vec;
            golden_d  = golden;
            vec_cnt_d = '0;
            settle_d  = '0;
            misr_load = 1'b1;
            if (num_vec == '0) begin
              state_d = ST_DONE;
              pass_d  = (SEED == golden);
            end else begin
              state_d = (SETTLE_CYC == 0) ? ST_ACCUM : ST_SETTLE;
              pass_d  = 1'b0;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_q == CNT_W'(SETTLE_CYC - 1)) state_d  = ST_ACCUM;
          else                                    settle_d = settle_q + 1'b1;
        end
        ST_ACCUM: begin
          if (resp_valid) begin
            misr_en   = 1'b1;
            vec_cnt_d = vec_cnt_q + 1'b1;
            // Last response: compare against the signature being written this edge.
            if (vec_cnt_d == num_q) begin
              state_d = ST_DONE;
              pass_d  = (sig_next == golden_q);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge blif_clk_net_1_r_15) begin
    if (blif_reset_net_1_r_15) begin
      state_q   <= ST_IDLE;
      vec_cnt_q <= '0;
      num_q     <= '0;
      settle_q  <= '0;
      golden_q  <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      num_q     <= num_d;
      settle_q  <= settle_d;
      golden_q  <= golden_d;
      pass_q    <= pass_d;
    end
  end

  assign busy    = (state_q == ST_SETTLE) || (state_q == ST_ACCUM);
  assign done    = (state_q == ST_DONE);
  assign pass    = pass_q;
  assign vec_cnt = vec_cnt_q;

endmodule

// File: tb/tb_pattern_resp_misr.sv
// Scoreboard bench for pattern_resp_misr: two instances (SEED 0x0000 and
// SEED 0x8000) share stimulus; expected run results are queued per instance
// and checked by monitors whenever done rises.
module tb_pattern_resp_misr;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst, start, clear, resp_valid;
  logic [11:0] num_vec;
  logic [15:0] golden;
  logic [8:0]  resp_in;

  logic        a_busy, a_done, a_pass, b_busy, b_done, b_pass;
  logic [15:0] a_sig, b_sig;
  logic [11:0] a_cnt, b_cnt;

  always #5 clk = ~clk;

  pattern_resp_misr #(.SEED(16'h0000)) dut_a (
    .blif_clk_net_1_r_15(clk), .blif_reset_net_1_r_15(rst),
    .start(start), .clear(clear), .num_vec(num_vec), .golden(golden),
    .resp_in(resp_in), .resp_valid(resp_valid),
    .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig), .vec_cnt(a_cnt)
  );

  pattern_resp_misr #(.SEED(16'h8000)) dut_b (
    .blif_clk_net_1_r_15(clk), .blif_reset_net_1_r_15(rst),
    .start(start), .clear(clear), .num_vec(num_vec), .golden(golden),
    .resp_in(resp_in), .resp_valid(resp_valid),
    .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .vec_cnt(b_cnt)
  );

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    logic [11:0] cnt;
  } exp_t;

  exp_t       exp_a[$], exp_b[$];
  exp_t       ea, eb;
  logic [8:0] resp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Signature as polynomial arithmetic over GF(2): S <- S*x mod (x^16+x^12+x^5+1) + r.
  function automatic logic [15:0] model_sig(input logic [15:0] seed);
    logic [16:0] s;
    s = {1'b0, seed};
    foreach (resp_q[i]) begin
      s = s << 1;
      if (s[16]) s = s ^ 17'h11021;
      s = s ^ {8'h00, resp_q[i]};
    end
    return s[15:0];
  endfunction

  // Monitors
  logic a_done_prev = 1'b0;
  logic b_done_prev = 1'b0;

  always @(negedge clk) begin
    if (a_done && !a_done_prev) begin
      if (exp_a.size() != 0) begin
        ea = exp_a.pop_front();
        check("a_signature", a_sig, ea.sig);
        check("a_pass",      a_pass, ea.pass);
        check("a_vec_cnt",   a_cnt, ea.cnt);
      end else begin
        n_cmp++; n_err++;
        $display("FAIL a_unexpected_done: got done=1, expected no completion");
      end
    end
    a_done_prev = a_done;
  end

  always @(negedge clk) begin
    if (b_done && !b_done_prev) begin
      if (exp_b.size() != 0) begin
        eb = exp_b.pop_front();
        check("b_signature", b_sig, eb.sig);
        check("b_pass",      b_pass, eb.pass);
        check("b_vec_cnt",   b_cnt, eb.cnt);
      end else begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected_done: got done=1, expected no completion");
      end
    end
    b_done_prev = b_done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One run using resp_q as the response list.
  task automatic run(input int num, input logic [15:0] gold, input bit settle_pulse,
                     input bit busy_starts);
    exp_t e;
    int   gaps;
    e.sig = model_sig(16'h0000); e.pass = (e.sig == gold); e.cnt = num[11:0];
    exp_a.push_back(e);
    e.sig = model_sig(16'h8000); e.pass = (e.sig == gold); e.cnt = num[11:0];
    exp_b.push_back(e);

    num_vec = num[11:0]; golden = gold; start = 1'b1;
    step();
    start = 1'b0; num_vec = 12'($urandom); golden = 16'($urandom);
    if (num == 0) begin
      check("zero_run_busy", a_busy, 0);
      check("zero_run_done", a_done, 1);
      return;
    end
    check("busy_after_start", a_busy, 1);
    repeat (SETTLE) begin
      resp_valid = settle_pulse ? 1'b1 : 1'($urandom_range(0, 1));
      resp_in    = 9'($urandom);
      step();
    end
    foreach (resp_q[i]) begin
      gaps = $urandom_range(0, 2);
      repeat (gaps) begin
        resp_valid = 1'b0;
        resp_in    = 9'($urandom);
        if (busy_starts && $urandom_range(0, 1) == 1) start = 1'b1;
        step();
        start = 1'b0;
      end
      resp_valid = 1'b1;
      resp_in    = resp_q[i];
      step();
    end
    resp_valid = 1'b0;
    check("a_done_latency", a_done, 1);
    check("b_done_latency", b_done, 1);
  endtask

  initial begin
    int          n;
    logic [15:0] g;
    rst = 1'b1; start = 1'b0; clear = 1'b0; resp_valid = 1'b0;
    num_vec = '0; golden = '0; resp_in = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    check("reset_sig_a", a_sig, 16'h0000);
    check("reset_sig_b", b_sig, 16'h8000);
    check("reset_busy",  a_busy, 0);
    check("reset_done",  a_done, 0);
    check("reset_pass",  a_pass, 0);
    check("reset_cnt",   a_cnt, 0);

    resp_q = '{9'h1FF};
    run(1, 16'h01FF, 1'b0, 1'b0);
    step();
    resp_q = '{9'h000};
    run(1, 16'h1020, 1'b0, 1'b0);
    step();
    resp_q = '{9'h001, 9'h000};
    run(2, 16'h0002, 1'b1, 1'b0);
    step();

    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 12);
      resp_q.delete();
      for (int k = 0; k < n; k++) resp_q.push_back(9'($urandom));
      g = ($urandom_range(0, 1) == 1) ? model_sig(16'h0000) : 16'($urandom);
      run(n, g, 1'b0, 1'b1);
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    // clear together with start in the middle of ACCUM
    num_vec = 12'd5; golden = 16'h1234; start = 1'b1;
    step();
    start = 1'b0;
    repeat (SETTLE) step();
    resp_valid = 1'b1; resp_in = 9'h0A5;
    repeat (2) step();
    resp_valid = 1'b0;
    check("mid_accum_cnt", a_cnt, 2);
    clear = 1'b1; start = 1'b1; num_vec = 12'd3;
    step();
    clear = 1'b0; start = 1'b0;
    check("clear_busy",  a_busy, 0);
    check("clear_done",  a_done, 0);
    check("clear_sig_a", a_sig, 16'h0000);
    check("clear_sig_b", b_sig, 16'h8000);
    check("clear_cnt",   a_cnt, 0);
    check("clear_pass",  a_pass, 0);
    repeat (3) step();
    check("clear_stays_idle", a_busy, 0);

    // zero-length run, then reset while in DONE
    resp_q.delete();
    run(0, 16'h0000, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_done_done",  a_done, 0);
    check("rst_done_pass",  a_pass, 0);
    check("rst_done_sig_b", b_sig, 16'h8000);
    check("rst_done_cnt",   b_cnt, 0);
    check("rst_done_busy",  b_busy, 0);
    repeat (2) step();
    check("scoreboard_drain", exp_a.size() + exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
